// File: rtl/esfa_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : esfa_op_sequencer
//  Purpose  : Sequences ESFA lookup/update/delete/retag commands over the
//             tuple-cell array through one read/write port, one cell per cycle.
//  Options  : ESFA_SEQ_EARLY_EXIT_EN - leave the scan on the first match
//             (lookup/update/delete).
//  Revision : 1.0 - initial release
// ============================================================================
module esfa_op_sequencer #(
    parameter int NUM_CELLS = 8,
    parameter int INDEX_W   = 8,
    parameter int VALUE_W   = 8,
    parameter int HANDLE_W  = 4,
    localparam int PTR_W    = $clog2(NUM_CELLS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [INDEX_W-1:0]  cmd_index,
    input  logic [VALUE_W-1:0]  cmd_value,
    input  logic [HANDLE_W-1:0] cmd_handle,
    input  logic [HANDLE_W-1:0] cmd_new_handle,
    output logic [PTR_W-1:0]    cell_sel,
    input  logic                cell_rd_valid,
    input  logic [INDEX_W-1:0]  cell_rd_index,
    input  logic [VALUE_W-1:0]  cell_rd_value,
    input  logic [HANDLE_W-1:0] cell_rd_handle,
    output logic                cell_wr_en,
    output logic                cell_wr_valid,
    output logic [INDEX_W-1:0]  cell_wr_index,
    output logic [VALUE_W-1:0]  cell_wr_value,
    output logic [HANDLE_W-1:0] cell_wr_handle,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic                rsp_found,
    output logic [VALUE_W-1:0]  rsp_value
);

    localparam logic [1:0] c_OP_LOOKUP = 2'd0;
    localparam logic [1:0] c_OP_UPDATE = 2'd1;
    localparam logic [1:0] c_OP_DELETE = 2'd2;
    localparam logic [1:0] c_OP_RETAG  = 2'd3;

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SCAN  = 2'd1;
    localparam logic [1:0] c_S_WRITE = 2'd2;
    localparam logic [1:0] c_S_RESP  = 2'd3;

    localparam logic [PTR_W-1:0] c_LAST_PTR = PTR_W'(NUM_CELLS - 1);

    logic [1:0]          r_state, w_state_next;
    logic                r_cmd_ready;
    logic [1:0]          r_op;
    logic [INDEX_W-1:0]  r_index;
    logic [VALUE_W-1:0]  r_value;
    logic [HANDLE_W-1:0] r_handle;
    logic [HANDLE_W-1:0] r_new_handle;
    logic [PTR_W-1:0]    r_ptr;
    logic                r_hit, r_free;
    logic [PTR_W-1:0]    r_hit_ptr, r_free_ptr;
    logic [VALUE_W-1:0]  r_count;
    logic                r_rsp_found;
    logic [VALUE_W-1:0]  r_rsp_value;

    logic                w_accept;
    logic                w_match, w_tag_hit, w_early_exit, w_scan_end;
    logic                w_need_write;
    logic [PTR_W-1:0]    w_wr_ptr;
    logic [VALUE_W-1:0]  w_count_next;

    assign w_match   = cell_rd_valid && (cell_rd_index == r_index) && (cell_rd_handle == r_handle);
    assign w_tag_hit = (r_op == c_OP_RETAG) && cell_rd_valid && (cell_rd_handle == r_handle);

`ifdef ESFA_SEQ_EARLY_EXIT_EN
    assign w_early_exit = w_match && (r_op != c_OP_RETAG);
`else
    assign w_early_exit = 1'b0;
`endif

    assign w_scan_end   = (r_ptr == c_LAST_PTR) || w_early_exit;
    // Hit/free status including the cell being read this cycle.
    assign w_need_write = ((r_op == c_OP_UPDATE) && (r_hit || w_match || r_free || !cell_rd_valid))
                       || ((r_op == c_OP_DELETE) && (r_hit || w_match));
    assign w_wr_ptr     = ((r_op == c_OP_UPDATE) && !r_hit) ? r_free_ptr : r_hit_ptr;
    assign w_count_next = !w_tag_hit ? r_count
                        : ((r_count == {VALUE_W{1'b1}}) ? r_count : r_count + 1'b1);

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = (r_state == c_S_RESP);
    assign rsp_found = r_rsp_found;
    assign rsp_value = r_rsp_value;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_S_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next   = r_state;
        w_accept       = 1'b0;
        cell_sel       = '0;
        cell_wr_en     = 1'b0;
        cell_wr_valid  = cell_rd_valid;
        cell_wr_index  = cell_rd_index;
        cell_wr_value  = cell_rd_value;
        cell_wr_handle = cell_rd_handle;
        case (r_state)
            c_S_IDLE: begin
                if (cmd_valid && r_cmd_ready) begin
                    w_accept     = 1'b1;
                    w_state_next = c_S_SCAN;
                end
            end
            c_S_SCAN: begin
                cell_sel = r_ptr;
                if (w_tag_hit) begin
                    cell_wr_en     = 1'b1;
                    cell_wr_handle = r_new_handle;
                end
                if (w_scan_end) w_state_next = w_need_write ? c_S_WRITE : c_S_RESP;
            end
            c_S_WRITE: begin
                cell_sel   = w_wr_ptr;
                cell_wr_en = 1'b1;
                if (r_op == c_OP_UPDATE) begin
                    cell_wr_valid  = 1'b1;
                    cell_wr_index  = r_index;
                    cell_wr_value  = r_value;
                    cell_wr_handle = r_handle;
                end else begin
                    cell_wr_valid  = 1'b0;
                end
                w_state_next = c_S_RESP;
            end
            c_S_RESP: begin
                if (rsp_ready) w_state_next = c_S_IDLE;
            end
            default: w_state_next = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_ready  <= 1'b0;
            r_op         <= '0;
            r_index      <= '0;
            r_value      <= '0;
            r_handle     <= '0;
            r_new_handle <= '0;
            r_ptr        <= '0;
            r_hit        <= 1'b0;
            r_free       <= 1'b0;
            r_hit_ptr    <= '0;
            r_free_ptr   <= '0;
            r_count      <= '0;
            r_rsp_found  <= 1'b0;
            r_rsp_value  <= '0;
        end else begin
            // Ready re-opens only once the FSM is back in IDLE.
            r_cmd_ready <= (w_state_next == c_S_IDLE);
            if (w_accept) begin
                r_op         <= cmd_op;
                r_index      <= cmd_index;
                r_value      <= cmd_value;
                r_handle     <= cmd_handle;
                r_new_handle <= cmd_new_handle;
                r_ptr        <= '0;
                r_hit        <= 1'b0;
                r_free       <= 1'b0;
                r_hit_ptr    <= '0;
                r_free_ptr   <= '0;
                r_count      <= '0;
                r_rsp_found  <= 1'b0;
                r_rsp_value  <= '0;
            end
            if (r_state == c_S_SCAN) begin
                r_ptr   <= r_ptr + 1'b1;
                r_count <= w_count_next;
                if (w_match && !r_hit) begin
                    r_hit     <= 1'b1;
                    r_hit_ptr <= r_ptr;
                    if (r_op == c_OP_LOOKUP) begin
                        r_rsp_found <= 1'b1;
                        r_rsp_value <= cell_rd_value;
                    end
                end
                if ((r_op == c_OP_UPDATE) && !cell_rd_valid && !r_free) begin
                    r_free     <= 1'b1;
                    r_free_ptr <= r_ptr;
                end
                if (w_scan_end && (r_op == c_OP_RETAG)) begin
                    r_rsp_found <= (w_count_next != '0);
                    r_rsp_value <= w_count_next;
                end
            end
            if (r_state == c_S_WRITE) r_rsp_found <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: doc/esfa_op_sequencer.md
# esfa_op_sequencer

Multi-cycle controller that sequences ESFA operations (lookup, update, delete, retag) over the memory-cell tuple array. It accepts one command at a time through a valid/ready handshake and scans the cells one per cycle through a single read/write port. It performs the required cell writes and returns one response through a second valid/ready handshake. It sits between the operation-select front end and the cell register array, and replaces ad-hoc parallel wiring of the update/lookup/delete/congruence units with a single sequenced access path.

## Interface
- NUM_CELLS, 8: number of tuple cells (power of two, ≥2); PTR_W = $clog2(NUM_CELLS)
- INDEX_W, 8: index field width
- VALUE_W, 8: value field width (≥ PTR_W+1)
- HANDLE_W, 4: handle field width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid / cmd_ready  in / out  1 / 1  command handshake
- cmd_op  in  2  0=LOOKUP, 1=UPDATE, 2=DELETE, 3=RETAG
- cmd_index, cmd_value, cmd_handle, cmd_new_handle  in  INDEX_W, VALUE_W, HANDLE_W, HANDLE_W  operands
- cell_sel  out  PTR_W  cell addressed this cycle
- cell_rd_valid, cell_rd_index, cell_rd_value, cell_rd_handle  in  1, INDEX_W, VALUE_W, HANDLE_W  combinational read of cell[cell_sel]
- cell_wr_en  out  1  write cell[cell_sel] at the clock edge
- cell_wr_valid, cell_wr_index, cell_wr_value, cell_wr_handle  out  1, INDEX_W, VALUE_W, HANDLE_W  write data
- rsp_valid / rsp_ready  out / in  1 / 1  response handshake
- rsp_found  out  1  operation hit/succeeded
- rsp_value  out  VALUE_W  lookup value, or RETAG count

## Operation
- States: IDLE, SCAN, WRITE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready, latch the operands, ptr←0, clear hit/free flags, go to SCAN.
- SCAN: cell_sel=ptr. match = cell_rd_valid && index==cmd_index && handle==cmd_handle.
  - LOOKUP: on match, latch rsp_value=cell_rd_value and rsp_found=1.
  - UPDATE: on match, record hit_ptr. The first invalid cell seen is recorded as free_ptr.
  - DELETE: on match, record hit_ptr.
  - RETAG: each valid cell with handle==cmd_handle is written in the same cycle with handle=cmd_new_handle, other fields unchanged. count increments; count saturates at 2^VALUE_W−1.
  - ptr increments. Scan ends after cell NUM_CELLS−1, or earlier per Configuration.
- Scan end:
  - UPDATE with a hit or a free cell, and DELETE with a hit, go to WRITE.
  - All other cases go to RESP.
- WRITE (one cycle):
  - UPDATE writes {valid=1, cmd_index, cmd_value, cmd_handle} to hit_ptr if there was a hit, else to free_ptr. rsp_found=1.
  - DELETE writes valid=0 to hit_ptr. rsp_found=1.
  - Go to RESP.
- RESP:
  - rsp_valid=1; payload is held stable until rsp_ready.
  - On rsp_valid&&rsp_ready, go to IDLE.
- Misses:
  - UPDATE with a full array and no hit: rsp_found=0, no write.
  - LOOKUP/DELETE miss: rsp_found=0, rsp_value=0.
  - RETAG: rsp_found=(count≠0), rsp_value=count.
- Duplicate matches: the first match (lowest ptr) wins.
- cell_wr_en is 0 outside SCAN (RETAG) and WRITE.

## Timing
- Reset (rst_n low, any state, mid-scan included):
  - state=IDLE; cmd_ready, cell_wr_en, rsp_valid, rsp_found are 0; rsp_value, cell_sel, ptr, count are 0.
  - cmd_ready is registered: it rises at the first clk edge after rst_n is released.
  - A write in progress is abandoned.
- cmd_ready is 0 from the accept edge until the cycle after the response handshake. There is no back-to-back acceptance.
- Full-scan latency, accept edge to rsp_valid:
  - NUM_CELLS+1 cycles without a write.
  - NUM_CELLS+2 cycles with WRITE.
- Cell read data must be valid in the same cycle as cell_sel. Writes take effect at the edge that ends the cycle.

## Configuration
- ESFA_SEQ_EARLY_EXIT_EN defined:
  - LOOKUP and DELETE leave SCAN in the cycle they see a match.
  - UPDATE leaves SCAN on a match.
  - A lookup hit at cell k gives rsp_valid k+2 cycles after the accept edge.
- ESFA_SEQ_EARLY_EXIT_EN undefined:
  - Every operation scans all NUM_CELLS cells, so latency is constant.
  - Results are identical (first match wins).

## Test plan
- Reset then UPDATE idx=5 val=0x3C h=2 into an empty array → cell 0 written {1,5,0x3C,2}, rsp_found=1. Full-scan latency 10 cycles (NUM_CELLS=8).
- LOOKUP idx=5 h=2 → rsp_found=1, rsp_value=0x3C. Latency 2 cycles with ESFA_SEQ_EARLY_EXIT_EN, 9 cycles without. LOOKUP idx=5 h=3 → rsp_found=0, rsp_value=0.
- Fill all 8 cells with distinct indices, then UPDATE a new idx=99 → rsp_found=0, no cell_wr_en pulse. UPDATE an existing idx → in-place overwrite.
- Three cells with h=2, RETAG h=2→7 → three write pulses during SCAN, rsp_value=3, rsp_found=1. A repeated RETAG gives rsp_value=0, rsp_found=0.
- DELETE a matching entry, with rsp_ready held low for 5 cycles → payload stable, cmd_ready=0 throughout. A following LOOKUP misses.
- Assert rst_n low during SCAN of an UPDATE → all outputs 0 immediately, no write. cmd_ready returns 1 one edge after release.
